// File: rtl/frame_loader.sv
// frame_loader: assembles a framed byte stream into one register-file write.
// A header byte 8'b10100_aaa (aaa != 3'b111) selects register aaa; the
// following 32 or 64 payload bytes are packed little-endian into a 512-bit
// word, then written with a one-cycle write_en pulse.
// Optional feature: define FRAME_LOADER_TIMEOUT_EN to abort a frame that
// stalls for TIMEOUT_CYCLES consecutive cycles in the payload phase.
module frame_loader #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic         write_en,
  output logic [2:0]   addr,
  output logic [511:0] write_data,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    WRITE   = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [5:0]   count_q, count_d;
  logic [2:0]   addr_q, addr_d;
  logic [511:0] data_q, data_d;
  logic         err_q, err_d;

  logic         accept;
  logic         hdr_ok;
  logic         short_frame;
  logic         last_byte;
  logic         timeout_hit;

  // Handshake and frame decode helpers.
  // in_ready is gated by rst so it reads 0 for the whole reset interval,
  // not just after the state register has been forced to IDLE.
  assign in_ready    = !rst && (state_q != WRITE);
  assign accept      = in_valid && in_ready;
  assign hdr_ok      = (in_data[7:3] == 5'b10100) && (in_data[2:0] != 3'b111);
  assign short_frame = (addr_q == 3'b010) || (addr_q == 3'b100);
  assign last_byte   = short_frame ? (count_q == 6'd31) : (count_q == 6'd63);

`ifdef FRAME_LOADER_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [IW-1:0] idle_q, idle_d;

  assign timeout_hit = (state_q == PAYLOAD) && !accept &&
                       (idle_q == IW'(TIMEOUT_CYCLES - 1));

  // Stall counter: counts consecutive payload cycles without an accepted byte.
  always_comb begin
    idle_d = idle_q;
    if ((state_q != PAYLOAD) || accept) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + IW'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, byte packing and error pulse generation.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an unassigned path in always_comb would infer a latch.
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (hdr_ok) begin
            addr_d  = in_data[2:0];
            data_d  = '0;
            count_d = '0;
            state_d = PAYLOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (accept) begin
          data_d[{count_q, 3'b000} +: 8] = in_data;
          count_d = count_q + 6'd1;
          if (last_byte) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        // addr/data are left untouched so they stay stable until the next
        // valid header clears them.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter, address and data registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the 512-bit data word is an output register, not a storage array,
    // and must read 0 during reset, so it is reset together with the rest.
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign write_en   = (state_q == WRITE);
  assign busy       = (state_q != IDLE);
  assign err        = err_q;
  assign addr       = addr_q;
  assign write_data = data_q;

endmodule

// File: tb/tb_frame_loader.sv
// tb_frame_loader: directed self-checking bench for frame_loader.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_frame_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         write_en;
  logic [2:0]   addr;
  logic [511:0] write_data;
  logic         busy;
  logic         err;

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  int err_cnt = 0;

  frame_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .write_en   (write_en),
    .addr       (addr),
    .write_data (write_data),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Pulse counters for write_en and err.
  always @(negedge clk) begin
    if (write_en === 1'b1) we_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  // Payload byte k for a given pattern kind.
  function automatic logic [7:0] pat(input int kind, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    case (kind)
      0:       pat = kb;
      1:       pat = 8'hFF;
      2:       pat = kb ^ 8'h5A;
      default: pat = kb + 8'd1;
    endcase
  endfunction

  // Expected 512-bit word for an n-byte frame of a given pattern.
  function automatic logic [511:0] exp_data(input int kind, input int n);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = pat(kind, k);
    return r;
  endfunction

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send(input logic [7:0] b, output int waits);
    waits = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (in_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk);
  endtask

  // Header followed by n payload bytes, with up to max_gap idle cycles before each byte.
  task automatic send_frame(input logic [7:0] hdr, input int n, input int kind,
                            input int max_gap, output int hdr_waits);
    int w;
    send(hdr, hdr_waits);
    for (int k = 0; k < n; k++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
      end
      send(pat(kind, k), w);
    end
  endtask

  // Capture outputs in the write cycle and in the cycle after it.
  task automatic observe_write(output logic we1, output logic rdy1, output logic bsy1,
                               output logic [2:0] a, output logic [511:0] d,
                               output logic we2, output logic bsy2);
    @(negedge clk);
    we1  = write_en;
    rdy1 = in_ready;
    bsy1 = busy;
    a    = addr;
    d    = write_data;
    in_valid = 1'b0;
    @(negedge clk);
    we2  = write_en;
    bsy2 = busy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    #3;
    tests++;
    if ({write_en, err, busy, in_ready, addr} !== 7'b0 || write_data !== 512'b0) begin
      fails++;
      $display("FAIL reset_outputs: we=%b err=%b busy=%b rdy=%b addr=%0d data_nz=%b, required all 0",
               write_en, err, busy, in_ready, addr, |write_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    logic we1, rdy1, bsy1, we2, bsy2;
    logic [2:0] a;
    logic [511:0] d;
    int w, we0;
    we0 = we_cnt;
    send_frame(8'hA0, 64, 0, 0, w);
    observe_write(we1, rdy1, bsy1, a, d, we2, bsy2);
    tests++;
    if ({we1, rdy1, bsy1, we2, bsy2} !== 5'b10100) begin
      fails++;
      $display("FAIL basic_timing: we/rdy/busy/we_next/busy_next=%b, required 10100",
               {we1, rdy1, bsy1, we2, bsy2});
    end
    tests++;
    if (a !== 3'd0) begin
      fails++;
      $display("FAIL basic_addr: got %0d, required 0", a);
    end
    tests++;
    if (d !== exp_data(0, 64)) begin
      fails++;
      $display("FAIL basic_data: low=%h high=%h, required low=00 high=3f", d[7:0], d[511:504]);
    end
    tests++;
    if (we_cnt - we0 !== 1) begin
      fails++;
      $display("FAIL basic_we_count: got %0d, required 1", we_cnt - we0);
    end
  endtask

  task automatic test_short_frame();
    logic we1, rdy1, bsy1, we2, bsy2;
    logic [2:0] a;
    logic [511:0] d;
    int w;
    send_frame(8'hA2, 32, 1, 0, w);
    observe_write(we1, rdy1, bsy1, a, d, we2, bsy2);
    tests++;
    if (we1 !== 1'b1 || a !== 3'd2) begin
      fails++;
      $display("FAIL short_write: we=%b addr=%0d, required 1/2", we1, a);
    end
    tests++;
    if (d[255:0] !== {256{1'b1}} || d[511:256] !== 256'b0) begin
      fails++;
      $display("FAIL short_data: low_all_ones=%b high_zero=%b, required 1/1",
               &d[255:0], ~|d[511:256]);
    end
    tests++;
    if (write_data !== d) begin
      fails++;
      $display("FAIL short_hold: write_data changed after write, required stable");
    end
  endtask

  task automatic test_bad_header();
    logic we1, rdy1, bsy1, we2, bsy2;
    logic [2:0] a;
    logic [511:0] d;
    int w, e0, we0;
    e0 = err_cnt;
    we0 = we_cnt;
    send(8'hA7, w);
    send(8'h55, w);
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL bad_hdr_state: err=%b busy=%b, required 1/0", err, busy);
    end
    send_frame(8'hA5, 64, 2, 0, w);
    observe_write(we1, rdy1, bsy1, a, d, we2, bsy2);
    tests++;
    if (err_cnt - e0 !== 2 || we_cnt - we0 !== 1) begin
      fails++;
      $display("FAIL bad_hdr_counts: err=%0d we=%0d, required 2/1", err_cnt - e0, we_cnt - we0);
    end
    tests++;
    if (a !== 3'd5 || d !== exp_data(2, 64)) begin
      fails++;
      $display("FAIL bad_hdr_write: addr=%0d data_ok=%b, required 5/1", a, d === exp_data(2, 64));
    end
  endtask

  task automatic test_gaps();
    logic we1, rdy1, bsy1, we2, bsy2;
    logic [2:0] a;
    logic [511:0] d;
    int w, we0;
    we0 = we_cnt;
    send_frame(8'hA6, 64, 0, 5, w);
    observe_write(we1, rdy1, bsy1, a, d, we2, bsy2);
    tests++;
    if (a !== 3'd6 || d !== exp_data(0, 64)) begin
      fails++;
      $display("FAIL gaps_write: addr=%0d data_ok=%b, required 6/1", a, d === exp_data(0, 64));
    end
    tests++;
    if (we_cnt - we0 !== 1) begin
      fails++;
      $display("FAIL gaps_we_count: got %0d, required 1", we_cnt - we0);
    end
  endtask

  task automatic test_mid_reset();
    logic we1, rdy1, bsy1, we2, bsy2;
    logic [2:0] a;
    logic [511:0] d;
    int w, we0;
    we0 = we_cnt;
    send_frame(8'hA1, 10, 0, 0, w);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({write_en, err, busy, in_ready, addr} !== 7'b0 || write_data !== 512'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: we=%b err=%b busy=%b rdy=%b addr=%0d data_nz=%b, required all 0",
               write_en, err, busy, in_ready, addr, |write_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_frame(8'hA1, 64, 3, 0, w);
    observe_write(we1, rdy1, bsy1, a, d, we2, bsy2);
    tests++;
    if (we_cnt - we0 !== 1 || a !== 3'd1 || d !== exp_data(3, 64)) begin
      fails++;
      $display("FAIL mid_reset_refill: we=%0d addr=%0d data_ok=%b, required 1/1/1",
               we_cnt - we0, a, d === exp_data(3, 64));
    end
  endtask

  task automatic test_back_to_back();
    logic we1, rdy1, bsy1, we2, bsy2;
    logic [2:0] a;
    logic [511:0] d;
    int w, hw, we0;
    we0 = we_cnt;
    send_frame(8'hA1, 64, 0, 0, w);
    // Next header is presented during the write cycle and must wait one cycle.
    send_frame(8'hA4, 32, 2, 0, hw);
    observe_write(we1, rdy1, bsy1, a, d, we2, bsy2);
    tests++;
    if (hw !== 1) begin
      fails++;
      $display("FAIL b2b_hdr_wait: got %0d cycles, required 1", hw);
    end
    tests++;
    if (we_cnt - we0 !== 2 || a !== 3'd4 || d !== exp_data(2, 32)) begin
      fails++;
      $display("FAIL b2b_write: we=%0d addr=%0d data_ok=%b, required 2/4/1",
               we_cnt - we0, a, d === exp_data(2, 32));
    end
  endtask

  task automatic test_timeout();
    int w, e0, we0;
    e0 = err_cnt;
    we0 = we_cnt;
    send_frame(8'hA3, 3, 0, 0, w);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
`ifdef FRAME_LOADER_TIMEOUT_EN
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_abort: err=%b busy=%b, required 1/0", err, busy);
    end
    @(negedge clk);
    #1;
    tests++;
    if (err !== 1'b0 || err_cnt - e0 !== 1 || we_cnt - we0 !== 0) begin
      fails++;
      $display("FAIL timeout_pulse: err=%b err_cnt=%0d we=%0d, required 0/1/0",
               err, err_cnt - e0, we_cnt - we0);
    end
`else
    tests++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL no_timeout_wait: busy=%b err=%b, required 1/0", busy, err);
    end
    @(negedge clk);
    #1;
    tests++;
    if (err_cnt - e0 !== 0 || we_cnt - we0 !== 0) begin
      fails++;
      $display("FAIL no_timeout_counts: err=%0d we=%0d, required 0/0", err_cnt - e0, we_cnt - we0);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL final_reset: busy=%b in_ready=%b, required 0/1", busy, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_frame();
    test_bad_header();
    test_gaps();
    test_mid_reset();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
